fsk_frame_rx: RTL
=================

// Module: fsk_frame_rx
// PURPOSE
//  Receive-side front end for the FSK link. Demodulates the 1-bit FSK line by counting rising
//  edges per bit window, hunts for a sync word and assembles the following 12-bit Hamming
//  codeword. Presents each codeword to the receive Hamming decoder with a one-cycle valid pulse.
//  Sits between the FSK line and the receive Hamming decoder, in the sample clock domain.
// PARAMETERS
//  SPB       16       samples (sysclk cycles) per bit window; power of two, >=8
//  EDGE_THR  3        rising edges in a window >= EDGE_THR -> bit 1 (mark), else 0 (space)
//  SYNC_W    4        sync word width
//  SYNC      4'b0110  sync pattern; first received bit is the MSB
//  WORD_W    12       codeword width; first received bit is the MSB
//  MISS_MAX  32       bit windows in HUNT without a sync match before locked drops
// PORTS
//  sysclk     in   1       sample clock; single clock domain
//  reset      in   1       asynchronous, active-low reset
//  fsk_in     in   1       raw FSK line; asynchronous to sysclk
//  dataout    out  WORD_W  last assembled codeword; held until the next frame completes
//  valid      out  1       one-cycle pulse when dataout updates
//  locked     out  1       high after the first good frame; cleared on miss timeout
//  bit_out    out  1       last sliced bit (debug)
//  bit_stb    out  1       one-cycle pulse when bit_out updates (debug)
// BEHAVIOUR
//  - Reset (reset==0): all outputs 0, state HUNT, phase and edge counters 0, shift registers 0.
//  - fsk_in passes through a 2-FF synchroniser, then a registered copy for rising-edge detect.
//  - Phase counter runs 0..SPB-1, free-running from reset release and wrapping.
//  - Edge counter: clog2(SPB)+1 bits, saturating. It adds 1 on each detected rising edge.
//  - At phase==SPB-1:
//    - bit = (edges_incl_this_cycle >= EDGE_THR);
//    - an edge on the SPB-1 cycle counts toward the closing window;
//    - the edge counter restarts at 0 for the next window.
//  - bit_out/bit_stb are registered one cycle after the phase==SPB-1 cycle.
//  - States, advanced only on bit_stb cycles:
//    - HUNT: shift the bit into sync_sr[SYNC_W-1:0].
//      - If {sync_sr[SYNC_W-2:0],bit}==SYNC, go to DATA, clear bit_cnt and miss_cnt.
//      - Otherwise increment miss_cnt (saturating). When miss_cnt reaches MISS_MAX, locked<=0.
//    - DATA: shift the bit into word_sr and increment bit_cnt.
//      - On the WORD_W-th bit, go to EMIT.
//      - Sync patterns appearing inside the data are ignored.
//    - EMIT (one cycle, the next sysclk):
//      - dataout<=word_sr, valid<=1, locked<=1, sync_sr<=0;
//      - return to HUNT.
//  - Latency:
//    - valid rises 2 cycles after the phase==SPB-1 cycle of the last data bit;
//    - the line-to-decision delay adds 3 cycles (2 synchroniser + 1 edge register).
//  - Back-to-back frames: the sync for the next frame may start on the window right after the
//    last data bit; no gap is required.
//  - Reset mid-frame aborts the partial word; dataout stays 0 until a full frame arrives.
//  - Idle (constant) line: 0 edges -> 0 bits; HUNT continues and miss_cnt saturates.
// STRUCTURE
//  - Package fsk_rx_pkg holds:
//    - state enum {HUNT, DATA, EMIT};
//    - defaults for SPB, EDGE_THR, SYNC, SYNC_W, WORD_W, MISS_MAX;
//    - the function clog2.
//  - Sub-module fsk_tone_slicer contains the synchroniser, edge detect, phase/edge counters and
//    bit decision (outputs bit_out, bit_stb).
//  - Framing FSM, shift registers and output registers live in the top.
// TESTING (tones: mark = toggle every 2 cycles (4 rises/window); space = toggle every 8 cycles
//          (1 rise/window); rises kept >=2 cycles away from window boundaries)
//  1. Idle line 0, 40 windows -> no valid; locked stays 0; bit_out 0 throughout.
//  2. Sync 0110 then 12'hA5C -> a single valid pulse, dataout=12'hA5C, locked=1, timed as above.
//  3. Two back-to-back frames 12'h001, 12'hFFF -> two valid pulses exactly 16*SPB cycles apart,
//     with the correct words.
//  4. Sync then a word containing 0110 (12'h666), then sync then 12'h123 -> dataout 12'h666,
//     then 12'h123; no early re-sync.
//  5. Reset pulse after 6 data bits of a frame -> no valid; outputs 0; the next full frame
//     decodes correctly.
//  6. Lock, then 32 windows of space with no sync -> locked falls on the 32nd miss; window with
//     exactly EDGE_THR rises -> bit 1, EDGE_THR-1 rises -> bit 0.

Source files
------------

// File: rtl/fsk_rx_pkg.sv
// Shared types, default parameters and helpers for the FSK receive front end.
package fsk_rx_pkg;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      DATA = 2'd1,
      EMIT = 2'd2
   } rx_state_t;

   localparam int              SPB_DEF      = 16;
   localparam int              EDGE_THR_DEF = 3;
   localparam int              SYNC_W_DEF   = 4;
   localparam logic [3:0]      SYNC_DEF     = 4'b0110;
   localparam int              WORD_W_DEF   = 12;
   localparam int              MISS_MAX_DEF = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fsk_tone_slicer.sv
// Line synchroniser, rising-edge detector and per-window edge counter that
// slices each bit window of the FSK line into a mark/space decision.
module fsk_tone_slicer
   import fsk_rx_pkg::*;
#(
   parameter int SPB      = SPB_DEF,
   parameter int EDGE_THR = EDGE_THR_DEF
) (
   input  logic sysclk,
   input  logic reset,
   input  logic fsk_in,
   output logic bit_out,
   output logic bit_stb
);

   localparam int              PH_W    = clog2(SPB);
   localparam int              EC_W    = PH_W + 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPB - 1);
   localparam logic [EC_W-1:0] EC_MAX  = {EC_W{1'b1}};
   localparam logic [EC_W-1:0] EC_THR  = EC_W'(EDGE_THR);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_prev;
   logic [PH_W-1:0] r_phase;
   logic [EC_W-1:0] r_edge_cnt;
   logic            r_bit_out;
   logic            r_bit_stb;

   logic            w_rise;
   logic            w_win_end;
   logic [EC_W-1:0] w_edges;

   // Edge count including a rise on the current cycle, so the closing cycle still counts.
   always_comb begin
      w_rise    = r_sync2 & ~r_prev;
      w_win_end = (r_phase == PH_LAST);
      if (w_rise && (r_edge_cnt != EC_MAX)) begin
         w_edges = r_edge_cnt + EC_W'(1);
      end else begin
         w_edges = r_edge_cnt;
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= fsk_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Phase wraps naturally because SPB is a power of two.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_phase    <= {PH_W{1'b0}};
         r_edge_cnt <= {EC_W{1'b0}};
      end else begin
         r_phase <= r_phase + PH_W'(1);
         if (w_win_end) begin
            r_edge_cnt <= {EC_W{1'b0}};
         end else begin
            r_edge_cnt <= w_edges;
         end
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_bit_out <= 1'b0;
         r_bit_stb <= 1'b0;
      end else begin
         r_bit_stb <= w_win_end;
         if (w_win_end) begin
            r_bit_out <= (w_edges >= EC_THR);
         end
      end
   end

   assign bit_out = r_bit_out;
   assign bit_stb = r_bit_stb;

endmodule

// File: rtl/fsk_frame_rx.sv
// FSK receive front end: slices line bits, hunts for the sync word and
// hands each following codeword to the Hamming decoder with a valid pulse.
module fsk_frame_rx
   import fsk_rx_pkg::*;
#(
   parameter int               SPB      = SPB_DEF,
   parameter int               EDGE_THR = EDGE_THR_DEF,
   parameter int               SYNC_W   = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC    = SYNC_DEF,
   parameter int               WORD_W   = WORD_W_DEF,
   parameter int               MISS_MAX = MISS_MAX_DEF
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              fsk_in,
   output logic [WORD_W-1:0] dataout,
   output logic              valid,
   output logic              locked,
   output logic              bit_out,
   output logic              bit_stb
);

   localparam int              BC_W      = clog2(WORD_W) + 1;
   localparam logic [BC_W-1:0] BC_LAST   = BC_W'(WORD_W - 1);
   localparam int              MC_W      = clog2(MISS_MAX) + 1;
   localparam logic [MC_W-1:0] MISS_SAT  = MC_W'(MISS_MAX);
   localparam logic [MC_W-1:0] MISS_LAST = MC_W'(MISS_MAX - 1);

   rx_state_t         r_state;
   rx_state_t         w_state_nxt;
   logic [SYNC_W-2:0] r_sync_sr;
   logic [WORD_W-2:0] r_word_sr;
   logic [BC_W-1:0]   r_bit_cnt;
   logic [MC_W-1:0]   r_miss_cnt;
   logic [WORD_W-1:0] r_dataout;
   logic              r_valid;
   logic              r_locked;

   logic              w_bit;
   logic              w_stb;
   logic [SYNC_W-1:0] w_sync_cat;
   logic              w_sync_hit;
   logic              w_miss;
   logic              w_emit;

   fsk_tone_slicer #(
      .SPB      (SPB),
      .EDGE_THR (EDGE_THR)
   ) u_slicer (
      .sysclk  (sysclk),
      .reset   (reset),
      .fsk_in  (fsk_in),
      .bit_out (w_bit),
      .bit_stb (w_stb)
   );

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Outputs are loaded on the transition into EMIT so valid is high during EMIT itself.
   always_comb begin
      w_state_nxt = r_state;
      w_sync_cat  = {r_sync_sr, w_bit};
      w_sync_hit  = 1'b0;
      w_miss      = 1'b0;
      w_emit      = 1'b0;
      case (r_state)
         HUNT: begin
            if (w_stb) begin
               if (w_sync_cat == SYNC) begin
                  w_sync_hit  = 1'b1;
                  w_state_nxt = DATA;
               end else begin
                  w_miss = 1'b1;
               end
            end else begin
               w_state_nxt = HUNT;
            end
         end
         DATA: begin
            if (w_stb && (r_bit_cnt == BC_LAST)) begin
               w_emit      = 1'b1;
               w_state_nxt = EMIT;
            end else begin
               w_state_nxt = DATA;
            end
         end
         EMIT: begin
            w_state_nxt = HUNT;
         end
         default: begin
            w_state_nxt = HUNT;
         end
      endcase
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_sync_sr  <= {(SYNC_W-1){1'b0}};
         r_word_sr  <= {(WORD_W-1){1'b0}};
         r_bit_cnt  <= {BC_W{1'b0}};
         r_miss_cnt <= {MC_W{1'b0}};
      end else begin
         if (r_state == EMIT) begin
            r_sync_sr <= {(SYNC_W-1){1'b0}};
         end else if ((r_state == HUNT) && w_stb) begin
            r_sync_sr <= w_sync_cat[SYNC_W-2:0];
         end
         if (w_sync_hit) begin
            r_bit_cnt <= {BC_W{1'b0}};
         end else if ((r_state == DATA) && w_stb) begin
            r_bit_cnt <= r_bit_cnt + BC_W'(1);
            r_word_sr <= {r_word_sr[WORD_W-3:0], w_bit};
         end
         if (w_sync_hit) begin
            r_miss_cnt <= {MC_W{1'b0}};
         end else if (w_miss && (r_miss_cnt != MISS_SAT)) begin
            r_miss_cnt <= r_miss_cnt + MC_W'(1);
         end
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_dataout <= {WORD_W{1'b0}};
         r_valid   <= 1'b0;
         r_locked  <= 1'b0;
      end else begin
         r_valid <= w_emit;
         if (w_emit) begin
            r_dataout <= {r_word_sr, w_bit};
            r_locked  <= 1'b1;
         end else if (w_miss && (r_miss_cnt >= MISS_LAST)) begin
            r_locked <= 1'b0;
         end
      end
   end

   assign dataout = r_dataout;
   assign valid   = r_valid;
   assign locked  = r_locked;
   assign bit_out = w_bit;
   assign bit_stb = w_stb;

endmodule
